fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction fetch/sequencing controller; the consumer end of the program counter interface.
- Sits between program_counter, the registered instruction ROM and the downsampling datapath.
- Watches the ROM byte stream addressed by the PC and drives the PC's jmp/jmp_addr/no_inc inputs.
- Issues single-byte datapath opcodes, stalls the PC for multi-cycle datapath ops, resolves 3-byte jumps.

Parameters:
- ADDR_W, 12, PC/instruction address width (must match program_counter).
- DATA_W, 8, instruction ROM word width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- pc_addr  in  ADDR_W  current PC value (program_counter addr_out).
- imem_rdata  in  DATA_W  ROM data; 1-cycle registered read: imem_rdata(t) = mem[pc_addr(t-1)].
- zero_flag  in  1  datapath zero flag, sampled for JZ.
- dp_busy  in  1  datapath multi-cycle op in progress.
- jmp  out  1  PC load enable.
- jmp_addr  out  ADDR_W  PC load value.
- no_inc  out  1  PC hold.
- ir  out  DATA_W  issued opcode (registered).
- ir_valid  out  1  one-cycle issue strobe (registered, aligned with ir).
- halted  out  1  sequencer in HALT.

Behaviour:
- Opcodes: 00 NOP; E0-EF WAIT-class; F0 JMP; F1 JZ; FF HALT; all others single-cycle datapath ops.
- JMP/JZ encoding: opcode, then hi byte (bits[3:0] = addr[11:8]), then lo byte (addr[7:0]).
- jmp, jmp_addr and no_inc are combinational from state, imem_rdata and rst_n; ir, ir_valid and halted are registered.
- While rst_n=0: jmp=1, jmp_addr=0, no_inc=1, ir=0, ir_valid=0, halted=0; next state BUBBLE. This forces the PC to 0, because program_counter has no reset.
- Reset mid-operation (any state) takes the same path, including aborting WAIT or HALT. Operand and link latches clear to 0.
- BUBBLE: discard imem_rdata; jmp=0, no_inc=0; -> DECODE.
- DECODE: imem_rdata is an opcode.
  - NOP: no issue; stay.
  - Single-cycle op: ir<=op, ir_valid<=1 next cycle; stay.
  - WAIT-class: issue as above, no_inc=1 this cycle; -> WAIT.
  - JMP/JZ: latch opcode; -> OPHI.
  - HALT: no_inc=1; -> HALT.
- WAIT: no_inc=dp_busy.
  - dp_busy=0: no_inc=0, -> DECODE. The ROM then delivers the byte after the WAIT opcode, so nothing is lost or duplicated.
  - dp_busy=1 in the first WAIT cycle holds.
- OPHI: latch imem_rdata[3:0]; -> OPLO.
- OPLO: take = JMP, or (JZ and zero_flag=1); zero_flag is sampled this cycle.
  - take=1: jmp=1, jmp_addr={hi,imem_rdata}; -> FLUSH.
  - take=0: -> DECODE.
- FLUSH: discard stale byte; -> DECODE. A taken jump costs exactly 1 bubble.
- HALT: no_inc=1, halted=1; held until reset.
- jmp and no_inc are never both asserted outside reset.
- ir_valid is never asserted for NOP, jump, HALT or operand bytes.
- Address wrap: a jump operand or byte stream at 12'hFFF wraps naturally through the PC; the sequencer applies no special case.

Optional Feature:
- Macro: FETCH_CALL_RET_EN.
- Defined: adds CALL (F2, 3-byte like JMP, always taken) and RET (F3, 1 byte).
  - CALL in OPLO: link <= pc_addr (address of next instruction), then jump.
  - RET in DECODE: jmp=1, jmp_addr=link; -> FLUSH.
  - Single-entry link register: a nested CALL overwrites it. Reset clears it to 0.
- Undefined: F2/F3 decode as single-cycle datapath ops (issued); no link register.

Decomposition:
- Package fetch_pkg: ADDR_W/DATA_W defaults, opcode constants (OP_NOP, OP_JMP, OP_JZ, OP_HALT, OP_CALL, OP_RET, WAIT class mask 8'hE0/8'hF0), state enum (BUBBLE, DECODE, WAIT, OPHI, OPLO, FLUSH, HALT).
- No sub-module; the FSM and operand/link latches are one block.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with PC at 12'h2A5 -> jmp=1, jmp_addr=0 each cycle. After release the PC steps 0,1,2…; the first issued ir = mem[0] and bubble byte is dropped.
- Straight line: ROM 00:11,01:00,02:22 -> ir_valid twice, ir=11 then 22; NOP not issued; no_inc never asserted.
- WAIT: ROM 05:E3,06:44, dp_busy high 4 cycles -> E3 issued once; PC held at 6 through the busy cycles; then 44 issued exactly once.
- JMP: ROM 10:F0,11:03,12:40,13:99 -> jmp=1 with jmp_addr=12'h340 for one cycle; 99 never issued; mem[340] is the next decoded byte.
- JZ: same layout with F1, zero_flag=0 -> no jmp, next decode at 13. With zero_flag=1 -> jump to 12'h340.
- HALT plus call/return: ROM 20:FF -> halted=1, PC frozen for 50 cycles, until rst_n pulse. With FETCH_CALL_RET_EN: CALL 12'h100 at 30, RET at 100 -> link=12'h033, execution resumes at 12'h033.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch sequencer.
// Optional CALL/RET support is enabled by defining FETCH_CALL_RET_EN.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 12;
  localparam int FETCH_DATA_W = 8;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_JMP  = 8'hF0;
  localparam logic [7:0] OP_JZ   = 8'hF1;
  localparam logic [7:0] OP_CALL = 8'hF2;
  localparam logic [7:0] OP_RET  = 8'hF3;
  localparam logic [7:0] OP_HALT = 8'hFF;

  // WAIT-class opcodes are E0..EF
  localparam logic [7:0] OP_WAIT_MASK = 8'hF0;
  localparam logic [7:0] OP_WAIT_VAL  = 8'hE0;

  typedef enum logic [2:0] {
    ST_BUBBLE,
    ST_DECODE,
    ST_WAIT,
    ST_OPHI,
    ST_OPLO,
    ST_FLUSH,
    ST_HALT
  } fetch_state_e;

  function automatic logic is_wait_op(input logic [7:0] op);
    return (op & OP_WAIT_MASK) == OP_WAIT_VAL;
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch/sequencing FSM: decodes the ROM byte stream and steers the PC.
// Define FETCH_CALL_RET_EN to add CALL (F2) / RET (F3) with a one-entry link register.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              zero_flag,
  input  logic              dp_busy,
  output logic              jmp,
  output logic [ADDR_W-1:0] jmp_addr,
  output logic              no_inc,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic              halted
);

  fetch_state_e      state_q, state_d;
  logic [7:0]        op_q, op_d;
  logic [3:0]        hi_q, hi_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic              halted_q, halted_d;
  logic [7:0]        op_byte;
  logic              is_jump_op;
  logic              take;

  assign op_byte = imem_rdata[7:0];

`ifdef FETCH_CALL_RET_EN
  logic [ADDR_W-1:0] link_q, link_d;
  assign is_jump_op = (op_byte == OP_JMP) || (op_byte == OP_JZ) || (op_byte == OP_CALL);
  assign take = (op_q == OP_JMP) || (op_q == OP_CALL) || ((op_q == OP_JZ) && zero_flag);
`else
  logic unused_pc;
  assign unused_pc  = ^pc_addr;
  assign is_jump_op = (op_byte == OP_JMP) || (op_byte == OP_JZ);
  assign take = (op_q == OP_JMP) || ((op_q == OP_JZ) && zero_flag);
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    hi_d       = hi_q;
    ir_d       = ir_q;
    ir_valid_d = 1'b0;
    halted_d   = 1'b0;
    jmp        = 1'b0;
    jmp_addr   = '0;
    no_inc     = 1'b0;
`ifdef FETCH_CALL_RET_EN
    link_d     = link_q;
`endif

    case (state_q)
      ST_BUBBLE: state_d = ST_DECODE;

      ST_DECODE: begin
        if (op_byte == OP_NOP) begin
          state_d = ST_DECODE;
        end else if (is_jump_op) begin
          op_d    = op_byte;
          state_d = ST_OPHI;
`ifdef FETCH_CALL_RET_EN
        end else if (op_byte == OP_RET) begin
          jmp      = 1'b1;
          jmp_addr = link_q;
          state_d  = ST_FLUSH;
`endif
        end else if (op_byte == OP_HALT) begin
          no_inc   = 1'b1;
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else begin
          ir_d       = imem_rdata;
          ir_valid_d = 1'b1;
          // Holding the PC here makes the ROM re-present the byte after WAIT on exit
          if (is_wait_op(op_byte)) begin
            no_inc  = 1'b1;
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        no_inc = dp_busy;
        if (!dp_busy) state_d = ST_DECODE;
      end

      ST_OPHI: begin
        hi_d    = op_byte[3:0];
        state_d = ST_OPLO;
      end

      ST_OPLO: begin
        if (take) begin
          jmp      = 1'b1;
          jmp_addr = ADDR_W'({hi_q, op_byte});
          state_d  = ST_FLUSH;
`ifdef FETCH_CALL_RET_EN
          // PC already points past the low operand byte: the return address
          if (op_q == OP_CALL) link_d = pc_addr;
`endif
        end else begin
          state_d = ST_DECODE;
        end
      end

      ST_FLUSH: state_d = ST_DECODE;

      ST_HALT: begin
        no_inc   = 1'b1;
        halted_d = 1'b1;
      end

      default: state_d = ST_BUBBLE;
    endcase

    // program_counter has no reset of its own, so reset drives it to 0
    if (!rst_n) begin
      jmp      = 1'b1;
      jmp_addr = '0;
      no_inc   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_BUBBLE;
      op_q       <= '0;
      hi_q       <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
`ifdef FETCH_CALL_RET_EN
      link_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      hi_q       <= hi_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
`ifdef FETCH_CALL_RET_EN
      link_q     <= link_d;
`endif
    end
  end

  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: PC + registered ROM model, issue scoreboard.
// CALL/RET scenario runs when FETCH_CALL_RET_EN is defined.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] pc = 12'h2A5;
  logic [7:0]  imem_rdata;
  logic        zero_flag;
  logic        dp_busy;
  logic        jmp;
  logic [11:0] jmp_addr;
  logic        no_inc;
  logic [7:0]  ir;
  logic        ir_valid;
  logic        halted;

  logic [7:0]  mem [0:4095];
  logic [7:0]  exp_q [$];
  logic [11:0] jmp_seen [$];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_addr    (pc),
    .imem_rdata (imem_rdata),
    .zero_flag  (zero_flag),
    .dp_busy    (dp_busy),
    .jmp        (jmp),
    .jmp_addr   (jmp_addr),
    .no_inc     (no_inc),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .halted     (halted)
  );

  // program_counter and registered ROM
  always_ff @(posedge clk) begin
    if (jmp) pc <= jmp_addr;
    else if (!no_inc) pc <= pc + 12'd1;
    imem_rdata <= mem[pc];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("jmp_noinc_excl", 32'(jmp && no_inc), 0);
      if (jmp) jmp_seen.push_back(jmp_addr);
      if (ir_valid) begin
        if (exp_q.size() == 0) begin
          check("unexp_issue", 32'(ir_valid), 0);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          $display("issue ir=%02h exp=%02h pc=%03h", ir, e, pc);
          check("issue", 32'(ir), 32'(e));
        end
      end
    end
  end

  function automatic logic [31:0] jmp_at(input int idx);
    if (jmp_seen.size() > idx) return 32'(jmp_seen[idx]);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic start_test();
    for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
    exp_q.delete();
    jmp_seen.delete();
    zero_flag = 1'b0;
    dp_busy   = 1'b0;
  endtask

  task automatic end_test();
    check("sb_drain", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_jmp", 32'(jmp), 1);
      check("rst_addr", 32'(jmp_addr), 0);
      check("rst_noinc", 32'(no_inc), 1);
      check("rst_irv", 32'(ir_valid), 0);
      check("rst_ir", 32'(ir), 0);
      check("rst_halt", 32'(halted), 0);
    end
    check("rst_pc", 32'(pc), 0);
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic found;
    rst_n     = 1'b0;
    zero_flag = 1'b0;
    dp_busy   = 1'b0;

    // Reset from PC 2A5, bubble byte dropped, first issue is mem[0]
    start_test();
    mem[0] = 8'h5A; mem[1] = 8'hFF;
    exp_q.push_back(8'h5A);
    do_reset();
    @(negedge clk); check("pc_step0", 32'(pc), 1);
    @(negedge clk); check("pc_step1", 32'(pc), 2);
    run(10);
    check("t1_halted", 32'(halted), 1);
    check("t1_pc", 32'(pc), 2);
    end_test();

    // Straight line with a NOP in between
    start_test();
    mem[0] = 8'h11; mem[1] = 8'h00; mem[2] = 8'h22; mem[3] = 8'hFF;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("line_noinc", 32'(no_inc), 0);
    end
    run(10);
    end_test();

    // WAIT with dp_busy high for 4 cycles
    start_test();
    mem[5] = 8'hE3; mem[6] = 8'h44; mem[7] = 8'hFF;
    exp_q.push_back(8'hE3); exp_q.push_back(8'h44);
    do_reset();
    dp_busy = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      if (ir_valid) found = 1'b1;
    end
    if (!found) begin
      check("wait_issue_timeout", 32'(ir_valid), 1);
      dp_busy = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        check("wait_pc", 32'(pc), 12'h006);
        check("wait_noinc", 32'(no_inc), 1);
        if (k == 3) dp_busy = 1'b0;
        else @(negedge clk);
      end
    end
    run(15);
    end_test();

    // JMP to 340, stale 99 must never issue
    start_test();
    mem['h10] = 8'hF0; mem['h11] = 8'h03; mem['h12] = 8'h40; mem['h13] = 8'h99; mem['h14] = 8'hFF;
    mem['h340] = 8'h5C; mem['h341] = 8'hFF;
    exp_q.push_back(8'h5C);
    do_reset();
    run(40);
    check("jmp_cnt", jmp_seen.size(), 1);
    check("jmp_target", jmp_at(0), 12'h340);
    end_test();

    // JZ not taken (zero_flag=0) then taken (zero_flag=1)
    for (int z = 0; z < 2; z++) begin
      start_test();
      mem['h10] = 8'hF1; mem['h11] = 8'h03; mem['h12] = 8'h40; mem['h13] = 8'h77; mem['h14] = 8'hFF;
      mem['h340] = 8'h5C; mem['h341] = 8'hFF;
      zero_flag = (z == 1);
      exp_q.push_back(z == 1 ? 8'h5C : 8'h77);
      do_reset();
      run(40);
      check("jz_cnt", jmp_seen.size(), z);
      if (z == 1) check("jz_target", jmp_at(0), 12'h340);
      end_test();
    end

    // HALT freezes the PC until a reset pulse
    start_test();
    mem['h20] = 8'hFF;
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (halted) found = 1'b1;
    end
    check("halt_reached", 32'(halted), 1);
    check("halt_pc", 32'(pc), 12'h021);
    run(50);
    check("halt_hold_pc", 32'(pc), 12'h021);
    check("halt_hold", 32'(halted), 1);
    check("halt_noinc", 32'(no_inc), 1);
    mem[0] = 8'h3C; mem[1] = 8'hFF;
    exp_q.push_back(8'h3C);
    do_reset();
    @(negedge clk);
    check("halt_cleared", 32'(halted), 0);
    run(10);
    check("halt_nojmp", jmp_seen.size(), 0);
    end_test();

`ifdef FETCH_CALL_RET_EN
    // CALL 100 from 30, RET returns to 33
    start_test();
    mem['h30] = 8'hF2; mem['h31] = 8'h01; mem['h32] = 8'h00; mem['h33] = 8'h66; mem['h34] = 8'hFF;
    mem['h100] = 8'hF3;
    exp_q.push_back(8'h66);
    do_reset();
    run(80);
    check("call_cnt", jmp_seen.size(), 2);
    check("call_target", jmp_at(0), 12'h100);
    check("ret_target", jmp_at(1), 12'h033);
    end_test();
`else
    // F2/F3 are ordinary datapath ops in this build
    start_test();
    mem[0] = 8'hF2; mem[1] = 8'hF3; mem[2] = 8'hFF;
    exp_q.push_back(8'hF2); exp_q.push_back(8'hF3);
    do_reset();
    run(10);
    check("f2f3_nojmp", jmp_seen.size(), 0);
    end_test();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
